obi_rr_arbiter: RTL and testbench
=================================

// Module: obi_rr_arbiter
// PURPOSE
// Shares one OBI subordinate port between NumMgr OBI manager ports (UseRReady=0 variant).
// Fair round-robin arbitration of the address phase; in-order response routing back to the
// issuing manager via an internal FIFO of manager indices (one entry per outstanding transaction).
// Sits between core/DMA-side managers and a shared memory or peripheral subordinate.
// PARAMETERS
// NumMgr     2   number of manager ports, >=2
// AddrWidth  32  address width
// DataWidth  32  data width; BE width = DataWidth/8
// MaxTrans   4   max outstanding transactions (index FIFO depth), >=1
// PORTS
// clk_i          in   1                   clock
// rst_ni         in   1                   async reset, active low
// mgr_req_i      in   NumMgr              per-manager address-phase request
// mgr_gnt_o      out  NumMgr              per-manager grant
// mgr_addr_i     in   NumMgr*AddrWidth    per-manager address
// mgr_we_i       in   NumMgr              per-manager write enable
// mgr_be_i       in   NumMgr*DataWidth/8  per-manager byte enables
// mgr_wdata_i    in   NumMgr*DataWidth    per-manager write data
// mgr_atop_i     in   NumMgr*6            per-manager atop (obi_pkg::atop_t), forwarded untouched
// mgr_rvalid_o   out  NumMgr              per-manager response valid
// mgr_rdata_o    out  DataWidth           read data, broadcast to all managers
// mgr_err_o      out  1                   error, broadcast; qualify with mgr_rvalid_o
// sbr_req_o      out  1                   subordinate request
// sbr_gnt_i      in   1                   subordinate grant
// sbr_addr_o/sbr_we_o/sbr_be_o/sbr_wdata_o/sbr_atop_o  out  as above  selected manager's fields
// sbr_rvalid_i   in   1                   subordinate response valid
// sbr_rdata_i    in   DataWidth           subordinate read data
// sbr_err_i      in   1                   subordinate error
// BEHAVIOUR
// - Reset: rr pointer=0, lock cleared, FIFO empty; all *_gnt_o, *_rvalid_o, sbr_req_o = 0.
// - Handshake = sbr_req_o & sbr_gnt_i. Request path fully combinational (0-cycle latency).
// - Selection: lowest index i in rotated order starting at ptr with mgr_req_i[i]=1.
// - Lock: if sbr_req_o=1 and sbr_gnt_i=0, lock the selected index; while locked, selection is
//   held regardless of other requests (OBI address-phase stability). Lock clears on handshake.
// - On handshake with index g: ptr <= (g+1) mod NumMgr; push g into FIFO.
// - sbr_req_o = |mgr_req_i & !fifo_full (locked: = !fifo_full is guaranteed true, full only rises on handshake).
// - mgr_gnt_o[g] = sbr_gnt_i & sbr_req_o for selected g only; other bits 0.
// - sbr_* payload muxed from selected manager; payload = manager 0 when no request (don't care).
// - FIFO full (MaxTrans outstanding): sbr_req_o=0, no grants; a same-cycle pop does NOT
//   unblock that cycle (req resumes next cycle).
// - Response: mgr_rvalid_o[head] = sbr_rvalid_i; pop FIFO on sbr_rvalid_i. Subordinate must
//   respond >=1 cycle after gnt, so push and pop of the same entry never coincide; push of a new
//   entry and pop of an older one in one cycle are allowed (count unchanged).
// - sbr_rvalid_i with FIFO empty: protocol violation; response dropped, all mgr_rvalid_o=0,
//   simulation assertion fires.
// - Count width $clog2(MaxTrans+1); pointers wrap modulo MaxTrans (non-power-of-two supported).
// - Async reset mid-transaction: all state cleared immediately; in-flight responses are lost,
//   integration must reset subordinate together.
// TESTING
// - Single mgr1 req, sbr_gnt_i=1 same cycle -> mgr_gnt_o=2'b10 cycle 0; rvalid 2 cycles later
//   with rdata=0xDEADBEEF -> mgr_rvalid_o=2'b10, mgr_rdata_o=0xDEADBEEF.
// - Both mgrs req continuously, gnt always 1 -> grants alternate 01,10,01,10 from reset (ptr=0).
// - mgr0 req, gnt held 0 for 3 cycles while mgr1 raises req -> sbr_addr_o stays mgr0 address,
//   gnt on cycle 4 goes to mgr0, mgr1 granted next.
// - MaxTrans=4, 4 handshakes without responses -> sbr_req_o=0 and mgr_gnt_o=0 on 5th request;
//   one rvalid -> req resumes following cycle; responses routed in issue order.
// - Interleaved issue 0,1,1,0 with delayed responses, err on 3rd -> mgr_rvalid_o sequence
//   01,10,10,01 with mgr_err_o=1 only on the 3rd.
// - Assert rst_ni low with 2 outstanding -> outputs 0 same cycle; after release ptr=0, FIFO empty.

Source files
------------

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI address-phase arbiter (no rready) sharing one subordinate between NumMgr managers.
// Responses are routed in order using a FIFO of issuing-manager indices.

module obi_rr_idx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned DataW = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    input  logic             pop_i,
    output logic [DataW-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Depth-1:0][DataW-1:0] mem_q;
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DepthCnt);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Explicit wrap so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module obi_rr_lane #(
    parameter int unsigned IdxW    = 1,
    parameter int unsigned LaneIdx = 0
) (
    input  logic [IdxW-1:0] sel_idx_i,
    input  logic            hs_i,
    input  logic [IdxW-1:0] head_idx_i,
    input  logic            rsp_en_i,
    output logic            gnt_o,
    output logic            rvalid_o
);
    assign gnt_o    = hs_i & (sel_idx_i == IdxW'(LaneIdx));
    assign rvalid_o = rsp_en_i & (head_idx_i == IdxW'(LaneIdx));
endmodule

module obi_rr_arbiter #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumMgr-1:0]                    mgr_req_i,
    output logic [NumMgr-1:0]                    mgr_gnt_o,
    input  logic [NumMgr-1:0][AddrWidth-1:0]     mgr_addr_i,
    input  logic [NumMgr-1:0]                    mgr_we_i,
    input  logic [NumMgr-1:0][DataWidth/8-1:0]   mgr_be_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]     mgr_wdata_i,
    input  logic [NumMgr-1:0][5:0]               mgr_atop_i,
    output logic [NumMgr-1:0]                    mgr_rvalid_o,
    output logic [DataWidth-1:0]                 mgr_rdata_o,
    output logic                                 mgr_err_o,
    output logic                                 sbr_req_o,
    input  logic                                 sbr_gnt_i,
    output logic [AddrWidth-1:0]                 sbr_addr_o,
    output logic                                 sbr_we_o,
    output logic [DataWidth/8-1:0]               sbr_be_o,
    output logic [DataWidth-1:0]                 sbr_wdata_o,
    output logic [5:0]                           sbr_atop_o,
    input  logic                                 sbr_rvalid_i,
    input  logic [DataWidth-1:0]                 sbr_rdata_i,
    input  logic                                 sbr_err_i
);
    localparam int unsigned IdxW = $clog2(NumMgr);
    localparam int unsigned SumW = IdxW + 1;
    localparam logic [IdxW-1:0] LastMgr = IdxW'(NumMgr - 1);

    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic                lock_q, lock_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]     rr_idx, sel_idx, pay_idx, head_idx;
    logic [SumW-1:0]     rr_sum;
    logic [2*NumMgr-1:0] req_rot;
    logic                rr_found, any_req, hs, rsp_en;
    logic                fifo_full, fifo_empty;

    assign any_req = |mgr_req_i;

    // Rotate requests so bit 0 is the manager at ptr, then take the first set bit.
    always_comb begin
        req_rot  = {mgr_req_i, mgr_req_i} >> ptr_q;
        rr_idx   = '0;
        rr_sum   = '0;
        rr_found = 1'b0;
        for (int unsigned k = 0; k < NumMgr; k++) begin
            if (!rr_found && req_rot[k]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, ptr_q} + SumW'(k);
                rr_idx   = (rr_sum >= SumW'(NumMgr)) ? IdxW'(rr_sum - SumW'(NumMgr)) : IdxW'(rr_sum);
            end
        end
    end

    // A pending, ungranted request must keep its address phase stable.
    assign sel_idx = lock_q ? lock_idx_q : rr_idx;
    assign pay_idx = any_req ? sel_idx : '0;

    assign sbr_req_o   = rst_ni & any_req & ~fifo_full;
    assign hs          = sbr_req_o & sbr_gnt_i;
    assign sbr_addr_o  = mgr_addr_i[pay_idx];
    assign sbr_we_o    = mgr_we_i[pay_idx];
    assign sbr_be_o    = mgr_be_i[pay_idx];
    assign sbr_wdata_o = mgr_wdata_i[pay_idx];
    assign sbr_atop_o  = mgr_atop_i[pay_idx];

    assign rsp_en      = sbr_rvalid_i & ~fifo_empty;
    assign mgr_rdata_o = sbr_rdata_i;
    assign mgr_err_o   = sbr_err_i;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            ptr_d  = (sel_idx == LastMgr) ? '0 : sel_idx + IdxW'(1);
            lock_d = 1'b0;
        end else if (sbr_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    obi_rr_idx_fifo #(
        .Depth (MaxTrans),
        .DataW (IdxW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (sel_idx),
        .pop_i   (sbr_rvalid_i),
        .head_o  (head_idx),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    for (genvar g = 0; g < NumMgr; g++) begin : g_lane
        obi_rr_lane #(
            .IdxW    (IdxW),
            .LaneIdx (g)
        ) u_lane (
            .sel_idx_i  (sel_idx),
            .hs_i       (hs),
            .head_idx_i (head_idx),
            .rsp_en_i   (rsp_en),
            .gnt_o      (mgr_gnt_o[g]),
            .rvalid_o   (mgr_rvalid_o[g])
        );
    end

    rvalid_needs_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_ni) sbr_rvalid_i |-> !fifo_empty);
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: hand-computed grant/response sequences with 2 managers,
// MaxTrans=4.

module tb_obi_rr_arbiter;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req, gnt, rvalid, we;
    logic [1:0][31:0] addr, wdata;
    logic [1:0][3:0]  be;
    logic [1:0][5:0]  atop;
    logic [31:0]      rdata, s_addr, s_wdata, s_rdata;
    logic             err, s_req, s_gnt, s_we, s_rvalid, s_err;
    logic [3:0]       s_be;
    logic [5:0]       s_atop;
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NumMgr(2), .AddrWidth(32), .DataWidth(32), .MaxTrans(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mgr_req_i(req), .mgr_gnt_o(gnt), .mgr_addr_i(addr), .mgr_we_i(we),
        .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_atop_i(atop),
        .mgr_rvalid_o(rvalid), .mgr_rdata_o(rdata), .mgr_err_o(err),
        .sbr_req_o(s_req), .sbr_gnt_i(s_gnt), .sbr_addr_o(s_addr), .sbr_we_o(s_we),
        .sbr_be_o(s_be), .sbr_wdata_o(s_wdata), .sbr_atop_o(s_atop),
        .sbr_rvalid_i(s_rvalid), .sbr_rdata_i(s_rdata), .sbr_err_i(s_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 2 units later.
    task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic e);
        @(negedge clk);
        req = r; s_gnt = g; s_rvalid = rv; s_err = e;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0;
        addr  = {32'h0000_1000, 32'h0000_0A00};
        wdata = {32'h1111_2222, 32'h3333_4444};
        we    = 2'b10;
        be    = {4'hC, 4'h3};
        atop  = {6'h2A, 6'h15};
        s_rdata = 32'hDEAD_BEEF;

        // Reset holds outputs low even with requests, grant and rvalid active
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        chk("rst_sbr_req", s_req, 0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        do_reset();

        // Single mgr1 transaction, response two cycles after grant
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t1_gnt", gnt, 2'b10);
        chk("t1_sbr_req", s_req, 1);
        chk("t1_addr", s_addr, 32'h0000_1000);
        chk("t1_wdata", s_wdata, 32'h1111_2222);
        chk("t1_we", s_we, 1);
        chk("t1_be", s_be, 4'hC);
        chk("t1_atop", s_atop, 6'h2A);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        chk("t1_idle_req", s_req, 0);
        chk("t1_idle_rvalid", rvalid, 2'b00);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t1_rvalid", rvalid, 2'b10);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        do_reset();

        // Both request continuously: grants alternate from ptr=0, responses follow issue order
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t2_gnt0", gnt, 2'b01);
        chk("t2_addr0", s_addr, 32'h0000_0A00);
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        chk("t2_gnt1", gnt, 2'b10);
        chk("t2_rv1", rvalid, 2'b01);
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        chk("t2_gnt2", gnt, 2'b01);
        chk("t2_rv2", rvalid, 2'b10);
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        chk("t2_gnt3", gnt, 2'b10);
        chk("t2_rv3", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t2_rv4", rvalid, 2'b10);

        // Move ptr to 1 so the lock is what keeps mgr0 selected
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t3_pre_gnt", gnt, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t3_pre_rv", rvalid, 2'b01);
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        chk("t3_c0_addr", s_addr, 32'h0000_0A00);
        chk("t3_c0_gnt", gnt, 2'b00);
        chk("t3_c0_req", s_req, 1);
        drive(2'b11, 1'b0, 1'b0, 1'b0);
        chk("t3_c1_addr", s_addr, 32'h0000_0A00);
        chk("t3_c1_gnt", gnt, 2'b00);
        drive(2'b11, 1'b0, 1'b0, 1'b0);
        chk("t3_c2_addr", s_addr, 32'h0000_0A00);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t3_c3_gnt", gnt, 2'b01);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t3_c4_gnt", gnt, 2'b10);
        chk("t3_c4_addr", s_addr, 32'h0000_1000);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t3_rv0", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t3_rv1", rvalid, 2'b10);

        // Fill FIFO (issue 0,1,0,1), block, pop without same-cycle unblock
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t4_g0", gnt, 2'b01);
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t4_g1", gnt, 2'b10);
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t4_g2", gnt, 2'b01);
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t4_g3", gnt, 2'b10);
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        chk("t4_full_req", s_req, 0);
        chk("t4_full_gnt", gnt, 2'b00);
        chk("t4_full_rv", rvalid, 2'b01);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t4_resume_req", s_req, 1);
        chk("t4_resume_gnt", gnt, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t4_rv1", rvalid, 2'b10);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t4_rv2", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t4_rv3", rvalid, 2'b10);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t4_rv4", rvalid, 2'b01);

        // Issue 0,1,1,0; delayed responses with error on the third
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t5_g0", gnt, 2'b01);
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t5_g1", gnt, 2'b10);
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t5_g2", gnt, 2'b10);
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t5_g3", gnt, 2'b01);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        chk("t5_gap", rvalid, 2'b00);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t5_rv0", rvalid, 2'b01);
        chk("t5_err0", err, 0);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t5_rv1", rvalid, 2'b10);
        chk("t5_err1", err, 0);
        drive(2'b00, 1'b0, 1'b1, 1'b1);
        chk("t5_rv2", rvalid, 2'b10);
        chk("t5_err2", err, 1);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t5_rv3", rvalid, 2'b01);
        chk("t5_err3", err, 0);

        // Reset with two outstanding, then prove ptr=0 and FIFO empty
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_err = 1'b0;
        #2;
        chk("t6_rst_req", s_req, 0);
        chk("t6_rst_gnt", gnt, 2'b00);
        chk("t6_rst_rv", rvalid, 2'b00);
        @(negedge clk);
        rst_n = 1'b1; s_gnt = 1'b0; s_rvalid = 1'b0;
        #2;
        chk("t6_post_req", s_req, 1);
        chk("t6_post_addr", s_addr, 32'h0000_0A00);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t6_g0", gnt, 2'b01);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t6_g1", gnt, 2'b10);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t6_g2", gnt, 2'b01);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t6_g3", gnt, 2'b10);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t6_full_req", s_req, 0);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t6_rv0", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t6_rv1", rvalid, 2'b10);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t6_rv2", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        chk("t6_rv3", rvalid, 2'b10);
        drive(2'b00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
